// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling, and a
// one-deep holding register on a valid/ready byte stream with parity/framing/overrun flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int    BYTESIZE = 8,
  parameter string PARITY   = "NONE",
  parameter int    STOPSIZE = 1,
  parameter int    N_BIT    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rxd,
  output logic [BYTESIZE-1:0] rx_data,
  output logic                rx_perr,
  output logic                rx_ferr,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_ovr
);

  // Handshake: a character moves when rx_valid & rx_ready on a rising edge;
  // while rx_valid & ~rx_ready, rx_data/rx_perr/rx_ferr hold stable.

  localparam int            CW      = $clog2(N_BIT);
  localparam logic [CW-1:0] HALF    = CW'((N_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST    = CW'(N_BIT - 1);
  localparam logic [3:0]    DLAST   = 4'(BYTESIZE - 1);
  localparam logic [3:0]    SLAST   = 4'(STOPSIZE - 1);
  localparam bit            HAS_PAR = (PARITY != "NONE");
  localparam bit            IS_ODD  = (PARITY == "ODD");

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sync1;
  logic                rxs;
  logic                rxs_q;
  logic                fall;
  logic                armed;
  logic [CW-1:0]       bcnt;
  logic [3:0]          idx;
  logic [BYTESIZE-1:0] shreg;
  logic                perr_q;
  logic                stop_or;
  logic                tick;
  logic                start_det;
  logic                start_smp;
  logic                deliver;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rxs   <= sync1;
      rxs_q <= rxs;
    end
  end

  assign fall = rxs_q & ~rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_det) state_nxt = START;
      START:   if (start_smp) state_nxt = rxs ? IDLE : DATA;
      DATA:    if (tick && idx == DLAST) state_nxt = HAS_PAR ? PAR : STOP;
      PAR:     if (tick) state_nxt = STOP;
      STOP:    if (deliver) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A high start-bit sample is treated as a glitch and drops back to IDLE.
  always_comb begin
    tick      = 1'b0;
    start_det = 1'b0;
    start_smp = 1'b0;
    case (state)
      IDLE:            start_det = armed & fall;
      START:           start_smp = (bcnt == HALF);
      DATA, PAR, STOP: tick      = (bcnt == LAST);
      default:         ;
    endcase
    deliver = (state == STOP) & tick & (idx == SLAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt    <= '0;
      idx     <= '0;
      armed   <= 1'b0;
      shreg   <= '0;
      perr_q  <= 1'b0;
      stop_or <= 1'b0;
    end else begin
      if (state == IDLE || start_smp || tick) bcnt <= '0;
      else                                    bcnt <= bcnt + 1'b1;

      if (state != state_nxt) idx <= '0;
      else if (tick)          idx <= idx + 1'b1;

      // A line held low never re-arms, so a break cannot retrigger a start.
      if (start_det)                 armed <= 1'b0;
      else if (state == IDLE && rxs) armed <= 1'b1;

      if (state == DATA && tick) shreg <= {rxs, shreg[BYTESIZE-1:1]};

      if (start_smp)                perr_q <= 1'b0;
      else if (state == PAR && tick)
        perr_q <= IS_ODD ? (rxs != ~^shreg) : (rxs != ^shreg);

      if (start_smp)                  stop_or <= 1'b0;
      else if (state == STOP && tick) stop_or <= stop_or | rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      rx_ovr <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_perr  <= perr_q;
          rx_ferr  <= ~(stop_or | rxs);
          rx_valid <= 1'b1;
        end else begin
          rx_ovr <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance fed from a shared
// frame driver, checked against a character-level model and an expected queue.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int N_BIT = 5;
  localparam int NOM   = 2 + (N_BIT - 1) / 2 + N_BIT * (8 + 0 + 1) + 1;

  logic       clk;
  logic       rst;
  logic       line;
  logic       sel;
  logic       rxd0, rxd1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_perr0, rx_perr1, rx_ferr0, rx_ferr1;
  logic       rx_valid0, rx_valid1, rx_ready0, rx_ready1, rx_ovr0, rx_ovr1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ovr_cnt0 = 0;
  int ovr_cnt1 = 0;
  int lat;
  logic valid0_d = 1'b0;

  logic [9:0] exp0_q[$];
  logic [9:0] exp1_q[$];
  int         lat_q[$];

  assign rxd0 = sel ? 1'b1 : line;
  assign rxd1 = sel ? line : 1'b1;

  uart_rx #(.BYTESIZE(8), .PARITY("NONE"), .STOPSIZE(1), .N_BIT(N_BIT)) u_dut0 (
    .clk(clk), .rst(rst), .uart_rxd(rxd0), .rx_data(rx_data0), .rx_perr(rx_perr0),
    .rx_ferr(rx_ferr0), .rx_valid(rx_valid0), .rx_ready(rx_ready0), .rx_ovr(rx_ovr0)
  );

  uart_rx #(.BYTESIZE(8), .PARITY("EVEN"), .STOPSIZE(1), .N_BIT(N_BIT)) u_dut1 (
    .clk(clk), .rst(rst), .uart_rxd(rxd1), .rx_data(rx_data1), .rx_perr(rx_perr1),
    .rx_ferr(rx_ferr1), .rx_valid(rx_valid1), .rx_ready(rx_ready1), .rx_ovr(rx_ovr1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Character-level reference: even parity means data plus parity bit carry
  // an even number of ones; a low stop bit is a framing error.
  function automatic logic [9:0] model(input logic [7:0] b, input bit par_en,
                                       input logic pbit, input logic stop_v);
    logic perr;
    perr = par_en && (($countones({b, pbit}) % 2) != 0);
    return {perr, ~stop_v, b};
  endfunction

  // driver tasks (all entered and left #1 after a rising edge)
  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      line = bits[i];
      repeat (N_BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop_v,
                            input bit want, input bit lat_en);
    logic pbit;
    pbit = (($countones(b) % 2) == 1) ^ bad_par;
    if (want) begin
      if (sel) exp1_q.push_back(model(b, 1'b1, pbit, stop_v));
      else     exp0_q.push_back(model(b, 1'b0, pbit, stop_v));
    end
    if (lat_en) lat_q.push_back(cyc);
    if (sel) send_bits({1'b0, stop_v, pbit, b, 1'b0}, 11);
    else     send_bits({2'b00, stop_v, b, 1'b0}, 10);
  endtask

  task automatic drain(input bit which);
    int n;
    n = 0;
    while ((which ? exp1_q.size() : exp0_q.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(which ? "drain1" : "drain0", 32'(which ? exp1_q.size() : exp0_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted character must match the head of its queue
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid0 && rx_ready0) begin
        if (exp0_q.size() == 0) check("rx0_spurious", 32'(rx_valid0), 32'd0);
        else check("rx0_char", 32'({rx_perr0, rx_ferr0, rx_data0}), 32'(exp0_q.pop_front()));
      end
      if (rx_valid1 && rx_ready1) begin
        if (exp1_q.size() == 0) check("rx1_spurious", 32'(rx_valid1), 32'd0);
        else check("rx1_char", 32'({rx_perr1, rx_ferr1, rx_data1}), 32'(exp1_q.pop_front()));
      end
      if (rx_ovr0) ovr_cnt0++;
      if (rx_ovr1) ovr_cnt1++;
      if (rx_valid0 && !valid0_d && lat_q.size() > 0) begin
        lat = cyc - lat_q.pop_front();
        check("latency", 32'((lat >= NOM - 1 && lat <= NOM + 1) ? NOM : lat), 32'(NOM));
      end
    end
    valid0_d = rx_valid0;
  end

  initial begin
    line = 1'b1; sel = 1'b0; rx_ready0 = 1'b1; rx_ready1 = 1'b1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_valid0), 32'd0);
    check("rst_data",  32'(rx_data0),  32'd0);
    check("rst_flags", 32'({rx_perr0, rx_ferr0, rx_ovr0}), 32'd0);
    rst = 1'b1;
    idle(4);

    // 8N1 back-to-back, latency checked
    send_frame(8'h48, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(8'h65, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    drain(1'b0);

    // even parity, good then bad parity bit
    sel = 1'b1;
    idle(2);
    send_frame(8'h6C, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    send_frame(8'h6C, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);
    drain(1'b1);
    sel = 1'b0;
    idle(2);

    // framing error followed by a break
    send_frame(8'h41, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check("break_chars", 32'(exp0_q.size()), 32'd0);
    idle(6);
    send_frame(8'h42, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    drain(1'b0);

    // one-clock glitch on an idle line, then a real frame
    idle(5);
    line = 1'b0;
    @(posedge clk);
    #1;
    idle(12);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    drain(1'b0);

    // overrun: second character dropped while the first is held
    rx_ready0 = 1'b0;
    send_frame(8'h31, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    @(negedge clk);
    check("ovr_hold_data",  32'(rx_data0), 32'h31);
    check("ovr_hold_valid", 32'(rx_valid0), 32'd1);
    check("ovr_pulse",      32'(ovr_cnt0), 32'd1);
    @(posedge clk);
    #1;
    rx_ready0 = 1'b1;
    @(posedge clk);
    #1;
    rx_ready0 = 1'b0;
    @(negedge clk);
    check("ovr_release_valid", 32'(rx_valid0), 32'd0);
    check("ovr_release_pop",   32'(exp0_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // reset mid-frame while a character is held
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_bits({3'b000, 8'h5A, 1'b0}, 5);
    rst = 1'b0;
    line = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(rx_valid0), 32'd0);
    check("midrst_data",  32'(rx_data0),  32'd0);
    check("midrst_flags", 32'({rx_perr0, rx_ferr0, rx_ovr0}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rx_ready0 = 1'b1;
    idle(4);
    send_frame(8'h21, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    drain(1'b0);

    // random 8N1 characters with random gaps
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b1, 1'b1);
      idle($urandom_range(2, 6));
    end
    idle(3);
    drain(1'b0);

    // random 8E1 characters with random parity corruption
    sel = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      idle($urandom_range(2, 6));
    end
    idle(3);
    drain(1'b1);
    sel = 1'b0;
    idle(5);

    check("ovr0_total",  32'(ovr_cnt0), 32'd1);
    check("ovr1_total",  32'(ovr_cnt1), 32'd0);
    check("lat_pending", 32'(lat_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Standalone UART receiver that deserialises the serial line driven by the UART transmitter's uart_txd output.
- Delivers each received character on a valid/ready byte stream, with per-character parity and framing error flags and an overrun pulse.
- Sits directly downstream of the UART transmit pin. Serves as the synthesizable line monitor in benches and as the receive front-end for Avalon-side logic.

Parameters:
- BYTESIZE, 8, data bits per character, LSB first; legal range 5..8.
- PARITY, "NONE", parity mode: "NONE", "ODD" or "EVEN".
- STOPSIZE, 1, stop bits checked; legal values 1 or 2.
- N_BIT, 5, clock cycles per bit (clock frequency / baud rate); minimum 3.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- uart_rxd  in  1  serial line, asynchronous to clk; idles high.
- rx_data  out  BYTESIZE  received character.
- rx_perr  out  1  parity error for rx_data; always 0 when PARITY="NONE".
- rx_ferr  out  1  framing error for rx_data: a stop bit was sampled 0.
- rx_valid  out  1  rx_data, rx_perr and rx_ferr are valid.
- rx_ready  in  1  consumer accepts the character.
- rx_ovr  out  1  one-cycle pulse: a character was dropped because the holding register was full.

Behaviour:
- Reset values: rx_valid=0, rx_ovr=0, rx_data=0, rx_perr=0, rx_ferr=0. Synchronizer flops = 1, FSM = IDLE, counters = 0, armed = 0.
- Input synchronizer: 2 flops, giving rxs. A previous-value flop on rxs detects falling edges. No other filtering.
- armed flag: set whenever rxs=1 in IDLE. A start is accepted only when armed=1 and a 1->0 transition of rxs is seen. A line held low (break) never retriggers.
- Baud counter: bcnt counts 0..N_BIT-1.
- FSM states:
  - IDLE: on start detect, bcnt=0, go to START.
  - START: at bcnt=(N_BIT-1)/2 (integer division), sample rxs.
    - Sample 1: false start (glitch). Return to IDLE, emit nothing.
    - Sample 0: bcnt=0, bit index=0, go to DATA.
  - DATA: sample rxs each time bcnt reaches N_BIT-1, i.e. every N_BIT clocks, so each sample falls mid-bit. Shift into bit[index]. After BYTESIZE samples, go to PARITY, or to STOP if PARITY="NONE".
  - PARITY: sample one bit.
    - ODD: perr = (sample != ~^data).
    - EVEN: perr = (sample != ^data).
  - STOP: sample STOPSIZE bits; ferr = OR over stop samples == 0. On the last stop sample, deliver the character and go to IDLE in the same cycle. IDLE re-arms only after rxs=1 is seen.
- Delivery, on the cycle after the last stop sample:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that cycle: load rx_data/rx_perr/rx_ferr and set rx_valid=1.
  - Otherwise: keep the old character, drop the new one, and pulse rx_ovr for 1 cycle.
- Handshake: a transfer occurs when rx_valid & rx_ready. rx_valid then drops next cycle unless a new delivery happens in the same cycle, in which case rx_valid stays 1 with new data. While rx_valid & ~rx_ready, outputs are held stable.
- Latency, from the uart_rxd falling edge to rx_valid rising: 2 + (N_BIT-1)/2 + N_BIT*(BYTESIZE + P + STOPSIZE) + 1 clocks, where P = 0 for "NONE", else 1. Tolerance is ±1 clock, due to synchronizer phase.
- Reset asserted mid-frame: all state returns to reset values and the partial character is discarded. After release, the first accepted start requires rxs to have been 1 (armed).

Test Plan:
- 8N1, N_BIT=5, rx_ready=1. Drive 'H' (0x48) then 'e' (0x65) back-to-back, one stop bit each -> two valid pulses with rx_data=0x48 then 0x65, perr=0, ferr=0. Each rx_valid rise occurs at the specified latency ±1 after its start edge.
- PARITY="EVEN". Drive 0x6C with correct parity bit 0 -> perr=0. Then drive 0x6C with parity bit 1 -> rx_data=0x6C, perr=1.
- Framing/break. Drive 0x41 with stop bit 0, then hold the line low for 30 clocks -> exactly one character (0x41, ferr=1). No further rx_valid until the line returns high and a new start arrives.
- Glitch. Drive a 1-clock low pulse on an idle line -> FSM returns to IDLE, no rx_valid. A following 0x55 frame is received correctly.
- Overrun. Hold rx_ready=0 and send 0x31 then 0x32 -> rx_data stays 0x31 with rx_valid=1, and rx_ovr pulses once at 0x32 delivery. Then raise rx_ready for 1 cycle -> rx_valid=0.
- Reset mid-frame. Assert rst after 4 data bits of 0x5A -> all outputs reset. Release and send 0x21 -> exactly one character 0x21, no errors.
